// File: rtl/ras.sv
// Return address stack: speculative stack driven by BTB predictions, committed stack driven by retirement.
// Latency: push/pop visible on ras_addr/ras_valid one cycle after the triggering edge; no same-cycle bypass.
// Backpressure: none; every input is consumed every cycle.
//
// Ports:
//   clk, reset_                  clock, async active-low reset (clears both stacks)
//   pred_valid_, pc              fetch slot valid (active-low) and its PC
//   btb_hit, btb_type            BTB hit and instruction type for pc
//   com_call_, com_return_       committed jump is call / return (active-low; both low = plain jump)
//   com_addr                     PC of the committed jump
//   flush_                       mispredict recovery (active-low): SPEC reloaded from COM
//   ras_valid, ras_addr          speculative stack non-empty / speculative top of stack

`ifndef AddrWidth
`define AddrWidth 32
`endif

`ifndef Enable_
`define Enable_ 1'b0
`endif

package ras_pkg;
  typedef enum logic [1:0] {
    BRTYPE_BRANCH = 2'd0,
    BRTYPE_JUMP   = 2'd1,
    BRTYPE_CALL   = 2'd2,
    BRTYPE_RET    = 2'd3
  } BrInstType_t;
endpackage

module ras
  import ras_pkg::*;
#(
  parameter int unsigned ADDR  = `AddrWidth,
  parameter int unsigned RAS_D = 8
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            pred_valid_,
  input  logic [ADDR-1:0] pc,
  input  logic            btb_hit,
  input  BrInstType_t     btb_type,
  input  logic            com_call_,
  input  logic            com_return_,
  input  logic [ADDR-1:0] com_addr,
  input  logic            flush_,
  output logic            ras_valid,
  output logic [ADDR-1:0] ras_addr
);

  localparam int unsigned PtrW = $clog2(RAS_D);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_D);

  // Stack storage; sp points at the next free slot, so the top lives at sp-1.
  logic [RAS_D-1:0][ADDR-1:0] spec_q, spec_d;
  logic [RAS_D-1:0][ADDR-1:0] com_q, com_d;
  logic [PtrW-1:0]            spec_sp_q, spec_sp_d;
  logic [PtrW-1:0]            com_sp_q, com_sp_d;
  logic [CntW-1:0]            spec_cnt_q, spec_cnt_d;
  logic [CntW-1:0]            com_cnt_q, com_cnt_d;

  // Event decode
  logic pred_en;
  logic pred_call;
  logic pred_ret;
  logic com_push;
  logic com_pop;

  assign pred_en   = (pred_valid_ == `Enable_) && btb_hit;
  assign pred_call = pred_en && (btb_type == BRTYPE_CALL);
  assign pred_ret  = pred_en && (btb_type == BRTYPE_RET);

  // Both call and return flagged on a commit means a plain jump: no stack effect.
  assign com_push  = !com_call_ && com_return_;
  assign com_pop   = com_call_ && !com_return_;

  // Committed stack next state
  always_comb begin
    com_d     = com_q;
    com_sp_d  = com_sp_q;
    com_cnt_d = com_cnt_q;
    if (com_push) begin
      // A push on a full stack lands on the oldest slot; count stays saturated.
      com_d[com_sp_q] = com_addr + ADDR'(4);
      com_sp_d        = com_sp_q + PtrW'(1);
      if (com_cnt_q != CntFull) begin
        com_cnt_d = com_cnt_q + CntW'(1);
      end
    end else if (com_pop && (com_cnt_q != '0)) begin
      com_sp_d  = com_sp_q - PtrW'(1);
      com_cnt_d = com_cnt_q - CntW'(1);
    end
  end

  // Speculative stack next state. A flush restores from the committed state
  // including this cycle's commit, and drops any same-cycle prediction.
  always_comb begin
    spec_d     = spec_q;
    spec_sp_d  = spec_sp_q;
    spec_cnt_d = spec_cnt_q;
    if (flush_ == 1'b0) begin
      spec_d     = com_d;
      spec_sp_d  = com_sp_d;
      spec_cnt_d = com_cnt_d;
    end else if (pred_call) begin
      spec_d[spec_sp_q] = pc + ADDR'(4);
      spec_sp_d         = spec_sp_q + PtrW'(1);
      if (spec_cnt_q != CntFull) begin
        spec_cnt_d = spec_cnt_q + CntW'(1);
      end
    end else if (pred_ret && (spec_cnt_q != '0)) begin
      spec_sp_d  = spec_sp_q - PtrW'(1);
      spec_cnt_d = spec_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      spec_q     <= '0;
      spec_sp_q  <= '0;
      spec_cnt_q <= '0;
      com_q      <= '0;
      com_sp_q   <= '0;
      com_cnt_q  <= '0;
    end else begin
      spec_q     <= spec_d;
      spec_sp_q  <= spec_sp_d;
      spec_cnt_q <= spec_cnt_d;
      com_q      <= com_d;
      com_sp_q   <= com_sp_d;
      com_cnt_q  <= com_cnt_d;
    end
  end

  assign ras_addr  = spec_q[spec_sp_q - PtrW'(1)];
  assign ras_valid = (spec_cnt_q != '0);

endmodule

// File: tb/tb_ras.sv
// Testbench for ras: directed scenarios plus randomized traffic against a queue-based stack model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: none in the DUT; the bench drives one event set per cycle.

module tb_ras;
  import ras_pkg::*;

  localparam int ADDR  = 32;
  localparam int RAS_D = 8;

  logic            clk;
  logic            reset_;
  logic            pred_valid_;
  logic [ADDR-1:0] pc;
  logic            btb_hit;
  BrInstType_t     btb_type;
  logic            com_call_;
  logic            com_return_;
  logic [ADDR-1:0] com_addr;
  logic            flush_;
  logic            ras_valid;
  logic [ADDR-1:0] ras_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: stacks as bounded queues, back = top, front = oldest.
  logic [ADDR-1:0] spec_m[$];
  logic [ADDR-1:0] com_m[$];

  ras #(.ADDR(ADDR), .RAS_D(RAS_D)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .pred_valid_(pred_valid_),
    .pc         (pc),
    .btb_hit    (btb_hit),
    .btb_type   (btb_type),
    .com_call_  (com_call_),
    .com_return_(com_return_),
    .com_addr   (com_addr),
    .flush_     (flush_),
    .ras_valid  (ras_valid),
    .ras_addr   (ras_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    pred_valid_ = 1'b1;
    pc          = '0;
    btb_hit     = 1'b0;
    btb_type    = BRTYPE_BRANCH;
    com_call_   = 1'b1;
    com_return_ = 1'b1;
    com_addr    = '0;
    flush_      = 1'b1;
  endtask

  // Advance one clock, applying the stack rules to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (!reset_) begin
      spec_m.delete();
      com_m.delete();
    end else begin
      if (!com_call_ && com_return_) begin
        com_m.push_back(com_addr + 32'd4);
        if (com_m.size() > RAS_D) void'(com_m.pop_front());
      end else if (com_call_ && !com_return_) begin
        if (com_m.size() > 0) void'(com_m.pop_back());
      end
      if (!flush_) begin
        spec_m = com_m;
      end else if (!pred_valid_ && btb_hit && btb_type == BRTYPE_CALL) begin
        spec_m.push_back(pc + 32'd4);
        if (spec_m.size() > RAS_D) void'(spec_m.pop_front());
      end else if (!pred_valid_ && btb_hit && btb_type == BRTYPE_RET) begin
        if (spec_m.size() > 0) void'(spec_m.pop_back());
      end
    end
    #1;
  endtask

  task automatic predict(input BrInstType_t t, input logic [ADDR-1:0] a);
    pred_valid_ = 1'b0;
    btb_hit     = 1'b1;
    btb_type    = t;
    pc          = a;
    tick();
    set_idle();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset_ = 1'b0;
    #3;
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %0b expected 0", ras_valid);
    end
    n_cmp++;
    if (ras_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_addr got %h expected 00000000", ras_addr);
    end
    tick();
    reset_ = 1'b1;
    tick();
    n_cmp++;
    if (ras_valid !== 1'b0 || ras_addr !== 32'h0) begin
      n_err++; $display("FAIL post_reset got valid=%0b addr=%h expected 0/00000000", ras_valid, ras_addr);
    end
  endtask

  task automatic test_call_push();
    do_reset();
    predict(BRTYPE_CALL, 32'h100);
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h104) begin
      n_err++; $display("FAIL call_push got valid=%0b addr=%h expected 1/00000104", ras_valid, ras_addr);
    end
    predict(BRTYPE_RET, 32'h500);
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL call_pop valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_nonpush_types();
    do_reset();
    predict(BRTYPE_BRANCH, 32'h40);
    predict(BRTYPE_JUMP, 32'h44);
    btb_hit = 1'b0; pred_valid_ = 1'b0; btb_type = BRTYPE_CALL; pc = 32'h48;
    tick();
    set_idle();
    btb_hit = 1'b1; pred_valid_ = 1'b1; btb_type = BRTYPE_CALL; pc = 32'h4c;
    tick();
    set_idle();
    n_cmp++;
    if (ras_valid !== 1'b0 || ras_addr !== 32'h0) begin
      n_err++; $display("FAIL nonpush got valid=%0b addr=%h expected 0/00000000", ras_valid, ras_addr);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      predict(BRTYPE_RET, 32'h80);
      n_cmp++;
      if (ras_valid !== 1'b0 || ras_addr !== 32'h0) begin
        n_err++; $display("FAIL underflow_%0d got valid=%0b addr=%h expected 0/00000000", i, ras_valid, ras_addr);
      end
    end
    // Count must still be 0: one push then one pop empties the stack.
    predict(BRTYPE_CALL, 32'h20);
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h24) begin
      n_err++; $display("FAIL underflow_push got valid=%0b addr=%h expected 1/00000024", ras_valid, ras_addr);
    end
    predict(BRTYPE_RET, 32'h20);
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL underflow_count valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_overflow();
    logic [ADDR-1:0] exp_a;
    do_reset();
    for (int k = 0; k < 9; k++) predict(BRTYPE_CALL, 32'h1000 + 32'h10 * k);
    for (int i = 0; i < 8; i++) begin
      exp_a = 32'h1084 - 32'h10 * i;
      n_cmp++;
      if (ras_valid !== 1'b1 || ras_addr !== exp_a) begin
        n_err++; $display("FAIL overflow_pop%0d got valid=%0b addr=%h expected 1/%h", i, ras_valid, ras_addr, exp_a);
      end
      predict(BRTYPE_RET, 32'h0);
    end
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL overflow_empty valid got %0b expected 0", ras_valid);
    end
    predict(BRTYPE_RET, 32'h0);
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL overflow_pop9 valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    predict(BRTYPE_CALL, 32'h100);
    predict(BRTYPE_CALL, 32'h200);
    n_cmp++;
    if (ras_addr !== 32'h204) begin
      n_err++; $display("FAIL b2b_push addr got %h expected 00000204", ras_addr);
    end
    predict(BRTYPE_RET, 32'h300);
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h104) begin
      n_err++; $display("FAIL b2b_pop got valid=%0b addr=%h expected 1/00000104", ras_valid, ras_addr);
    end
  endtask

  task automatic test_flush();
    do_reset();
    com_call_ = 1'b0; com_addr = 32'h200;
    tick();
    set_idle();
    predict(BRTYPE_CALL, 32'h300);
    predict(BRTYPE_CALL, 32'h400);
    n_cmp++;
    if (ras_addr !== 32'h404) begin
      n_err++; $display("FAIL flush_pre addr got %h expected 00000404", ras_addr);
    end
    flush_ = 1'b0;
    tick();
    set_idle();
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h204) begin
      n_err++; $display("FAIL flush_restore got valid=%0b addr=%h expected 1/00000204", ras_valid, ras_addr);
    end
    predict(BRTYPE_RET, 32'h0);
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_count valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    flush_ = 1'b0; com_call_ = 1'b0; com_addr = 32'h500;
    pred_valid_ = 1'b0; btb_hit = 1'b1; btb_type = BRTYPE_CALL; pc = 32'h600;
    tick();
    set_idle();
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h504) begin
      n_err++; $display("FAIL simul_flush got valid=%0b addr=%h expected 1/00000504", ras_valid, ras_addr);
    end
    // Plain jump commit must leave COM alone.
    com_call_ = 1'b0; com_return_ = 1'b0; com_addr = 32'h700;
    tick();
    set_idle();
    flush_ = 1'b0;
    tick();
    set_idle();
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h504) begin
      n_err++; $display("FAIL simul_jump got valid=%0b addr=%h expected 1/00000504", ras_valid, ras_addr);
    end
    predict(BRTYPE_RET, 32'h0);
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL simul_discard valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    com_call_ = 1'b0; com_addr = 32'h900;
    tick();
    set_idle();
    for (int k = 0; k < 3; k++) predict(BRTYPE_CALL, 32'h700 + 32'h10 * k);
    n_cmp++;
    if (ras_valid !== 1'b1 || ras_addr !== 32'h724) begin
      n_err++; $display("FAIL async_pre got valid=%0b addr=%h expected 1/00000724", ras_valid, ras_addr);
    end
    #2;
    reset_ = 1'b0;
    #1;
    spec_m.delete();
    com_m.delete();
    n_cmp++;
    if (ras_valid !== 1'b0 || ras_addr !== 32'h0) begin
      n_err++; $display("FAIL async_reset got valid=%0b addr=%h expected 0/00000000", ras_valid, ras_addr);
    end
    // Reset dominates flush and commit across an edge.
    flush_ = 1'b0; com_call_ = 1'b0; com_addr = 32'hA00;
    tick();
    set_idle();
    reset_ = 1'b1;
    flush_ = 1'b0;
    tick();
    set_idle();
    n_cmp++;
    if (ras_valid !== 1'b0) begin
      n_err++; $display("FAIL async_override valid got %0b expected 0", ras_valid);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      pred_valid_ = ($urandom_range(0, 3) == 0);
      btb_hit     = ($urandom_range(0, 4) != 0);
      btb_type    = BrInstType_t'($urandom_range(0, 3));
      r           = $urandom_range(0, 7);
      pc          = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r           = $urandom_range(0, 5);
      com_call_   = !(r == 0 || r == 2);
      com_return_ = !(r == 1 || r == 2);
      com_addr    = $urandom;
      flush_      = ($urandom_range(0, 15) != 0);
      tick();
      n_cmp++;
      if (ras_valid !== (spec_m.size() != 0)) begin
        n_err++; $display("FAIL rand_valid cycle %0d got %0b expected %0b", c, ras_valid, spec_m.size() != 0);
      end
      if (spec_m.size() != 0) begin
        n_cmp++;
        if (ras_addr !== spec_m[$]) begin
          n_err++; $display("FAIL rand_addr cycle %0d got %h expected %h", c, ras_addr, spec_m[$]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    reset_ = 1'b1;
    set_idle();
    #1;
    test_reset();
    test_call_push();
    test_nonpush_types();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
